bus_port_fifo: RTL

- Per-device port adapter between one device and one port of the bus generator/arbiter (`bs_gnrtr_n_rbtr`).
- TX side: buffers device packets and presents them to the bus with the pndng/D_pop/pop handshake.
- RX side: captures push/D_push from the bus, keeps packets addressed to this port or to broadcast, and buffers them for the device.
- Replaces the behavioural FIFO model the bus bench drivers currently emulate; one instance per driver port.

---
 rtl/bus_port_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/bus_port_fifo.sv | 111 +++++++++++
 3 files changed

// File: rtl/bus_port_pkg.sv
// ============================================================================
// Module   : bus_port_pkg
// Brief    : Shared types, constants and helpers for the bus port adapter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bus_port_pkg;

    localparam int          MAX_PCKG_SZ   = 64;
    localparam logic [7:0]  BROADCAST_DEF = 8'hFF;

    typedef logic [7:0] cnt8_t;

    // Destination ID is the top byte of a packet of sz bits (sz <= MAX_PCKG_SZ).
    function automatic logic [7:0] dest_of(input logic [MAX_PCKG_SZ-1:0] pkt,
                                           input int                     sz);
        return 8'(pkt >> (sz - 8));
    endfunction

    function automatic cnt8_t sat_inc(input cnt8_t c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Synchronous show-ahead FIFO with occupancy counter and ovf pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_rd,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_rd;
    logic w_do_wr;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

    // A pop frees the slot in the same cycle, so a write into a full FIFO
    // still succeeds when it coincides with a pop.
    assign w_do_rd = i_rd && !o_empty;
    assign w_do_wr = i_wr && (!o_full || w_do_rd);
    assign o_ovf   = i_wr && o_full && !w_do_rd;

    assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_rd && !w_do_wr) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_port_fifo.sv
// ============================================================================
// Module   : bus_port_fifo
// Brief    : Device-to-bus port adapter: TX/RX FIFOs, RX address filter, counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_port_fifo
    import bus_port_pkg::*;
#(
    parameter int         PCKG_SZ   = 16,
    parameter int         DEPTH     = 8,
    parameter logic [7:0] ID        = 8'd0,
    parameter logic [7:0] BROADCAST = BROADCAST_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dev_push,
    input  logic [PCKG_SZ-1:0] dev_din,
    output logic               dev_full,
    output logic               pndng,
    output logic [PCKG_SZ-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [PCKG_SZ-1:0] D_push,
    output logic               rx_pndng,
    output logic [PCKG_SZ-1:0] rx_dout,
    input  logic               rx_pop,
    output logic [7:0]         tx_ovf_cnt,
    output logic [7:0]         rx_ovf_cnt,
    output logic [7:0]         rx_drop_cnt
);

    logic                   w_tx_empty;
    logic                   w_tx_ovf;
    logic                   w_rx_empty;
    logic                   w_rx_full;
    logic                   w_rx_ovf;
    logic [MAX_PCKG_SZ-1:0] w_pkt_ext;
    logic [7:0]             w_dest;
    logic                   w_match;
    logic                   w_rx_wr;

    cnt8_t r_tx_ovf_cnt;
    cnt8_t r_rx_ovf_cnt;
    cnt8_t r_rx_drop_cnt;

    sync_fifo #(
        .WIDTH (PCKG_SZ),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_wr    (dev_push),
        .i_din   (dev_din),
        .i_rd    (pop),
        .o_full  (dev_full),
        .o_empty (w_tx_empty),
        .o_dout  (D_pop),
        .o_ovf   (w_tx_ovf)
    );

    assign pndng = !w_tx_empty;

    assign w_pkt_ext = MAX_PCKG_SZ'(D_push);
    assign w_dest    = dest_of(w_pkt_ext, PCKG_SZ);
    assign w_match   = (w_dest == ID) || (w_dest == BROADCAST);
    assign w_rx_wr   = push && w_match;

    sync_fifo #(
        .WIDTH (PCKG_SZ),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_wr    (w_rx_wr),
        .i_din   (D_push),
        .i_rd    (rx_pop),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_dout  (rx_dout),
        .o_ovf   (w_rx_ovf)
    );

    assign rx_pndng = !w_rx_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_ovf_cnt  <= '0;
            r_rx_ovf_cnt  <= '0;
            r_rx_drop_cnt <= '0;
        end else begin
            if (w_tx_ovf) begin
                r_tx_ovf_cnt <= sat_inc(r_tx_ovf_cnt);
            end
            if (w_rx_ovf) begin
                r_rx_ovf_cnt <= sat_inc(r_rx_ovf_cnt);
            end
            if (push && !w_match) begin
                r_rx_drop_cnt <= sat_inc(r_rx_drop_cnt);
            end
        end
    end

    assign tx_ovf_cnt  = r_tx_ovf_cnt;
    assign rx_ovf_cnt  = r_rx_ovf_cnt;
    assign rx_drop_cnt = r_rx_drop_cnt;

endmodule

`default_nettype wire
